delaychain_sequencer: RTL and testbench

DELAYCHAIN_SEQUENCER -- requirements
Module: delaychain_sequencer

---
 rtl/delaychain_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_delaychain_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/delaychain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : delaychain_sequencer
//  Purpose  : Runs a programmable number of launch/check trials through an
//             attached delay chain. Each trial toggles the launch bit, waits
//             out the chain latency and compares the captured bit against
//             the launch bit. Mismatches are counted and the first failing
//             trial index is recorded.
//  Ports    :
//    clk            - system clock, all state updates on its rising edge
//    rst            - synchronous active-high reset
//    start_i        - run request, honoured only in IDLE
//    trials_i       - number of trials for the run (sampled with start_i)
//    test_mode_i    - chain path select for the run (sampled with start_i)
//    chain_din_o    - registered launch data to the chain
//    chain_test_o   - registered path select to the chain
//    chain_dout_i   - captured data returned by the chain
//    busy_o         - high while a run is in progress
//    done_o         - one-cycle pulse at run completion
//    err_count_o    - mismatching trials in the last run
//    first_fail_o   - index of the first mismatching trial, all-ones if none
//    pass_o         - last run completed with no mismatches
//  Revision : 1.0  initial release
// ============================================================================
module delaychain_sequencer #(
  parameter int LAT = 2,   // launch-to-capture latency of the chain, 2..16
  parameter int CW  = 8    // width of trial count, error count, fail index
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [CW-1:0] trials_i,
  input  logic          test_mode_i,
  output logic          chain_din_o,
  output logic          chain_test_o,
  input  logic          chain_dout_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] err_count_o,
  output logic [CW-1:0] first_fail_o,
  output logic          pass_o
);

  // Wait counter is wide enough for the largest legal latency.
  localparam int               c_wait_w    = 5;
  localparam logic [c_wait_w-1:0] c_wait_load = c_wait_w'(LAT - 2);
  localparam logic [CW-1:0]    c_no_fail   = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         trials_q, trials_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [c_wait_w-1:0]   wait_q, wait_d;
  logic                  din_q, din_d;
  logic                  test_q, test_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         err_q, err_d;
  logic [CW-1:0]         ff_q, ff_d;
  logic                  pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      trials_q <= '0;
      idx_q    <= '0;
      wait_q   <= '0;
      din_q    <= 1'b0;
      test_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
      ff_q     <= c_no_fail;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      trials_q <= trials_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      din_q    <= din_d;
      test_q   <= test_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    trials_d = trials_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    din_d    = din_q;
    test_d   = test_q;
    err_d    = err_q;
    ff_d     = ff_q;
    pass_d   = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          trials_d = trials_i;
          test_d   = test_mode_i;
          err_d    = '0;
          ff_d     = c_no_fail;
          pass_d   = 1'b0;
          idx_d    = '0;
          if (trials_i != '0) begin
            state_d = S_LAUNCH;
            // Toggle on entry so the new launch value spans the LAUNCH cycle.
            din_d   = ~din_q;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        wait_d  = c_wait_load;
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_CHECK: begin
        // Captured bit must equal the bit launched LAT cycles earlier,
        // which is still the current launch value.
        if (chain_dout_i != din_q) begin
          err_d = err_q + 1'b1;
          if (ff_q == c_no_fail) begin
            ff_d = idx_q;
          end
        end
        if (idx_q == trials_q - 1'b1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LAUNCH;
          din_d   = ~din_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      // Uses the post-check count so the final trial's result is included.
      pass_d = (err_d == '0);
    end
  end

  assign chain_din_o  = din_q;
  assign chain_test_o = test_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_count_o  = err_q;
  assign first_fail_o = ff_q;
  assign pass_o       = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_delaychain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_delaychain_sequencer
//  Purpose  : Self-checking bench for delaychain_sequencer with a two-stage
//             register chain model, stuck-at-0 and per-trial corruption.
//  Revision : 1.0  initial release
// ============================================================================
module tb_delaychain_sequencer;

  localparam int LAT = 2;
  localparam int CW  = 8;
  localparam int P   = LAT + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] trials = '0;
  logic          test_mode = 1'b0;
  logic          chain_din;
  logic          chain_test;
  logic          chain_dout;
  logic          busy;
  logic          done;
  logic [CW-1:0] err_count;
  logic [CW-1:0] first_fail;
  logic          pass;

  // Chain environment: din register then dout register.
  logic s1 = 1'b0;
  logic s2 = 1'b0;
  logic stuck = 1'b0;
  logic flip = 1'b0;
  logic model_din = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s1 <= chain_din;
    s2 <= s1;
  end
  assign chain_dout = (stuck ? 1'b0 : s2) ^ flip;

  delaychain_sequencer #(.LAT(LAT), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .trials_i     (trials),
    .test_mode_i  (test_mode),
    .chain_din_o  (chain_din),
    .chain_test_o (chain_test),
    .chain_dout_i (chain_dout),
    .busy_o       (busy),
    .done_o       (done),
    .err_count_o  (err_count),
    .first_fail_o (first_fail),
    .pass_o       (pass)
  );

  // One complete run. Entered and left just after a falling edge in IDLE.
  // Expected results come from the trial rules: trial k launches the
  // (k+1)-th toggle of the launch bit and compares what the chain returns.
  task automatic do_run(input int ntr, input logic tm, input logic stk,
                        input int pct, input bit hold, input bit toggle_tm);
    bit            corrupt [256];
    int            total;
    int            n;
    logic [CW-1:0] e_err;
    logic [CW-1:0] e_ff;
    logic          e_pass;
    logic          din_c;
    logic          e_din;
    logic          obs;
    total = ntr * P;
    din_c = model_din;
    e_err = '0;
    e_ff  = '1;
    for (int k = 0; k < ntr; k++) begin
      corrupt[k] = ($urandom_range(0, 99) < pct);
      din_c = ~din_c;
      obs   = (stk ? 1'b0 : din_c) ^ corrupt[k];
      if (obs != din_c) begin
        e_err++;
        if (e_ff == '1) e_ff = CW'(k);
      end
    end
    e_pass = (e_err == '0);

    stuck     = stk;
    start     = 1'b1;
    trials    = CW'(ntr);
    test_mode = tm;
    @(negedge clk);
    if (!hold) start = 1'b0;

    for (int c = 0; c <= total; c++) begin
      n     = (c < total) ? (c / P + 1) : ntr;
      e_din = model_din ^ n[0];
      n_checks++;
      if ({busy, done, chain_test, chain_din} !== {1'b1, (c == total), tm, e_din}) begin
        n_fail++;
        $display("FAIL run_ctrl c=%0d got busy/done/test/din=%b required=%b", c,
                 {busy, done, chain_test, chain_din}, {1'b1, (c == total), tm, e_din});
      end
      if (c == 0 && total > 0) begin
        n_checks++;
        if ({err_count, first_fail, pass} !== {{CW{1'b0}}, {CW{1'b1}}, 1'b0}) begin
          n_fail++;
          $display("FAIL run_clear got err=%0d ff=%0h pass=%b required err=0 ff=all-ones pass=0",
                   err_count, first_fail, pass);
        end
      end
      if (c == total) begin
        n_checks++;
        if ({err_count, first_fail, pass} !== {e_err, e_ff, e_pass}) begin
          n_fail++;
          $display("FAIL run_result trials=%0d got err=%0d ff=%0h pass=%b required err=%0d ff=%0h pass=%b",
                   ntr, err_count, first_fail, pass, e_err, e_ff, e_pass);
        end
      end
      // Corruption applies exactly at each trial's compare cycle; elsewhere
      // the returned bit is noise the sequencer must not look at.
      if (c < total && (c % P) == LAT) flip = corrupt[c / P];
      else                             flip = 1'($urandom_range(0, 1));
      if (toggle_tm) test_mode = ~test_mode;
      @(negedge clk);
    end
    flip      = 1'b0;
    model_din = din_c;
    n_checks++;
    if ({busy, done, chain_test, chain_din, err_count, first_fail, pass} !==
        {1'b0, 1'b0, tm, model_din, e_err, e_ff, e_pass}) begin
      n_fail++;
      $display("FAIL run_hold got busy=%b done=%b test=%b din=%b err=%0d ff=%0h pass=%b required busy=0 done=0 test=%b din=%b err=%0d ff=%0h pass=%b",
               busy, done, chain_test, chain_din, err_count, first_fail, pass,
               tm, model_din, e_err, e_ff, e_pass);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, chain_test, chain_din, err_count, first_fail, pass} !==
        {4'b0000, {CW{1'b0}}, {CW{1'b1}}, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values got busy=%b done=%b test=%b din=%b err=%0d ff=%0h pass=%b",
               busy, done, chain_test, chain_din, err_count, first_fail, pass);
    end
    rst = 1'b0;
    start = 1'b0;
    model_din = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle got busy/done=%b required=00", {busy, done});
    end
  endtask

  task automatic test_basic();
    do_run(4, 1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_zero();
    do_run(4, 1'b1, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_trials();
    do_run(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Start held through a whole run, then a second run accepted directly
    // from the following IDLE cycle.
    do_run(3, 1'b1, 1'b0, 30, 1'b1, 1'b0);
    do_run(2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    start = 1'b1;
    trials = CW'(3);
    test_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Cycle 0 is trial 0 LAUNCH; trial 1 LAUNCH is cycle P, WAIT follows.
    repeat (P + 1) @(negedge clk);
    n_checks++;
    if ({busy, done, chain_test} !== 3'b101) begin
      n_fail++;
      $display("FAIL midrun_busy got busy/done/test=%b required=101", {busy, done, chain_test});
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, chain_test, chain_din, err_count, first_fail, pass} !==
        {4'b0000, {CW{1'b0}}, {CW{1'b1}}, 1'b0}) begin
      n_fail++;
      $display("FAIL midrun_reset got busy=%b done=%b test=%b din=%b err=%0d ff=%0h pass=%b",
               busy, done, chain_test, chain_din, err_count, first_fail, pass);
    end
    rst = 1'b0;
    start = 1'b0;
    model_din = 1'b0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00) begin
        n_fail++;
        $display("FAIL midrun_no_done i=%0d got busy/done=%b required=00", i, {busy, done});
      end
    end
    do_run(3, 1'b0, 1'b0, 40, 1'b0, 1'b0);
  endtask

  task automatic test_mode_toggle();
    do_run(2, 1'b0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      do_run(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 60)),
             1'b0, 1'($urandom_range(0, 1)));
    end
    // Largest trial count: error count reaches its maximum without wrapping.
    do_run(255, 1'b1, 1'b0, 100, 1'b0, 1'b0);
    do_run(255, 1'b0, 1'b0, 20, 1'b0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stuck_zero();
    test_zero_trials();
    test_back_to_back();
    test_reset_midrun();
    test_mode_toggle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
